// File: rtl/ldl_rr_dispatch.sv
// ldl_rr_dispatch: round-robin dispatcher from one valid/ready stream
// into REQ_WIDTH consumers through a one-entry registered output stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   producer has a word
//   in_ready   word accepted this cycle (free slot or slot draining now)
//   in_data    producer payload, sampled only on capture
//   out_ready  per-consumer ready
//   out_valid  one-hot valid toward the locked destination, 0 when idle
//   out_data   held payload, shared by all consumers
//   bin        binary index of the current or last destination
module ldl_rr_dispatch #(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [REQ_WIDTH-1:0]  out_ready,
  output logic [REQ_WIDTH-1:0]  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [BIN_WIDTH-1:0]  bin
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BIN_WIDTH-1:0]  sel_q, sel_d;
  logic [BIN_WIDTH-1:0]  ptr_q, ptr_d;
  logic [REQ_WIDTH-1:0]  valid_q, valid_d;

  logic                  hs;
  logic                  cap;
  logic [BIN_WIDTH-1:0]  sel_inc;
  logic [BIN_WIDTH-1:0]  start;
  logic [BIN_WIDTH-1:0]  pick;
  logic [BIN_WIDTH-1:0]  idx;
  logic                  found;

  assign hs       = (state_q == FULL) & out_ready[sel_q];
  assign in_ready = rst & ((state_q == EMPTY) | hs);
  assign cap      = in_valid & in_ready;
  // REQ_WIDTH is a power of two, so the natural wrap is the modulo
  assign sel_inc  = sel_q + 1'b1;

  // First ready consumer at or after the start pointer; fall back to
  // start itself so a word is never refused for lack of a ready bit.
  always_comb begin
    start = hs ? sel_inc : ptr_q;
    pick  = start;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < REQ_WIDTH; k++) begin
      idx = start + BIN_WIDTH'(k);
      if (!found && out_ready[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: if (cap) state_d = FULL;
      FULL:  if (hs && !cap) state_d = EMPTY;
    endcase
    if (cap) begin
      data_d = in_data;
      sel_d  = pick;
    end
    if (hs) ptr_d = sel_inc;
    valid_d = (state_d == FULL) ? (REQ_WIDTH'(1) << sel_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign bin       = sel_q;

endmodule

// File: tb/tb_ldl_rr_dispatch.sv
// tb_ldl_rr_dispatch: directed scenarios plus random traffic against a
// behavioural slot/pointer model and an in-order word scoreboard.
module tb_ldl_rr_dispatch;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] bin;

  int n_chk = 0;
  int n_err = 0;

  // model: one slot (full/data/dest) plus a rotating start pointer
  int         m_full = 0;
  int         m_sel  = 0;
  int         m_ptr  = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] sb[$];

  logic       o_rdy;
  logic [7:0] o_valid;
  logic [7:0] o_data;
  int         o_bin;

  ldl_rr_dispatch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .bin       (bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v,
                     input logic [7:0] d, input logic [7:0] rd);
    logic       e_rdy;
    logic       hs;
    logic       cap;
    int         start;
    int         pick;
    logic [7:0] front;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = rd;
    #1;
    e_rdy = r && (m_full == 0 || rd[m_sel]);
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("out_valid", 32'(out_valid), m_full != 0 ? (32'd1 << m_sel) : 0);
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("bin", 32'(bin), 32'(m_sel));
    o_rdy = in_ready; o_valid = out_valid;
    o_data = out_data; o_bin = int'(bin);
    if (!r) begin
      m_full = 0; m_sel = 0; m_ptr = 0; m_data = 8'h00;
      sb.delete();
    end else begin
      hs  = (m_full != 0) && rd[m_sel];
      cap = v && e_rdy;
      start = hs ? (m_sel + 1) % N : m_ptr;
      if (hs) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          front = sb.pop_front();
          chk("sb_order", 32'(out_data), 32'(front));
        end
        m_ptr = (m_sel + 1) % N;
      end
      if (cap) begin
        pick = start;
        for (int k = N - 1; k >= 0; k--)
          if (rd[(start + k) % N]) pick = (start + k) % N;
        m_sel = pick; m_data = d;
        sb.push_back(d);
      end
      m_full = (cap || (m_full != 0 && !hs)) ? 1 : 0;
    end
  endtask

  logic [2:0] sp_bin[6];
  logic [7:0] sp_vld[6];

  initial begin
    sp_bin = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2};
    sp_vld = '{8'h01, 8'h04, 8'h20, 8'h80, 8'h01, 8'h04};
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 8'h00;
    repeat (2) @(posedge clk);

    // reset held with a pending word
    cyc(0, 1, 8'h55, 8'hFF);
    cyc(0, 1, 8'h55, 8'hFF);
    chk("rst_rdy", 32'(o_rdy), 0);
    chk("rst_vld", 32'(o_valid), 0);
    cyc(1, 1, 8'h55, 8'hFF);
    chk("rel_rdy", 32'(o_rdy), 1);
    cyc(1, 0, 8'h00, 8'hFF);
    chk("rel_bin", 32'(o_bin), 0);
    chk("rel_data", 32'(o_data), 32'h55);

    // full rotation
    cyc(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1, i < 9, 8'(8'h10 + i), 8'hFF);
      if (i < 9) chk("rot_rdy", 32'(o_rdy), 1);
      if (i > 0) begin
        chk("rot_bin", 32'(o_bin), (i - 1) % 8);
        chk("rot_data", 32'(o_data), 32'h10 + i - 1);
      end
    end

    // sparse ready pattern
    cyc(0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++) begin
      cyc(1, i < 6, 8'(8'h20 + i), 8'hA5);
      if (i > 0) begin
        chk("sp_bin", 32'(o_bin), 32'(sp_bin[i-1]));
        chk("sp_vld", 32'(o_valid), 32'(sp_vld[i-1]));
      end
    end

    // backpressure on bin 3
    cyc(0, 0, 8'h00, 8'h00);
    cyc(1, 1, 8'h33, 8'h08);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 8'h44, 8'($urandom) & 8'hF7);
      chk("bp_vld", 32'(o_valid), 32'h08);
      chk("bp_data", 32'(o_data), 32'h33);
      chk("bp_rdy", 32'(o_rdy), 0);
    end
    cyc(1, 1, 8'h44, 8'hFF);
    chk("bp_hs_rdy", 32'(o_rdy), 1);
    cyc(1, 0, 8'h00, 8'h00);
    chk("bp_next_bin", 32'(o_bin), 4);
    chk("bp_next_data", 32'(o_data), 32'h44);

    // nobody ready, pointer at 5
    cyc(0, 0, 8'h00, 8'h00);
    cyc(1, 1, 8'h01, 8'h10);
    cyc(1, 0, 8'h00, 8'h10);
    cyc(1, 1, 8'h77, 8'h00);
    cyc(1, 0, 8'h00, 8'h01);
    chk("nr_bin", 32'(o_bin), 5);
    cyc(1, 0, 8'h00, 8'h20);
    chk("nr_vld", 32'(o_valid), 32'h20);
    cyc(1, 1, 8'h88, 8'hFF);
    chk("nr_idle", 32'(o_valid), 0);
    cyc(1, 0, 8'h00, 8'h00);
    chk("nr_ptr6", 32'(o_bin), 6);

    // mid-operation reset drops the word held for bin 6
    cyc(0, 0, 8'h00, 8'h00);
    cyc(1, 0, 8'h00, 8'hFF);
    chk("mr_bin", 32'(o_bin), 0);
    chk("mr_vld", 32'(o_valid), 0);
    cyc(1, 0, 8'h00, 8'hFF);
    chk("mr_gone", 32'(o_valid), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rd;
      case ($urandom_range(3))
        0: rd = 8'h00;
        1: rd = 8'hFF;
        default: rd = 8'($urandom) & 8'($urandom);
      endcase
      cyc($urandom_range(63) != 0, 1'($urandom_range(1)),
          8'($urandom), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ldl_rr_dispatch.md
# ldl_rr_dispatch

Round-robin dispatcher: the distributing counterpart of the round-robin arbiter. It accepts one valid/ready input stream and delivers each word to exactly one of REQ_WIDTH consumers. Destinations rotate fairly among ready consumers. A one-entry registered output stage holds each word and its destination stable until the chosen consumer accepts it. It sits where a shared producer feeds a bank of identical workers.

## Interface
- BIN_WIDTH, 3, width of the destination index.
- REQ_WIDTH, 1 << BIN_WIDTH, number of consumers.
- DATA_WIDTH, 8, payload width.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 resets on the next rising edge.
- in_valid  in  1  producer has a word.
- in_ready  out  1  dispatcher accepts the word this cycle.
- in_data  in  DATA_WIDTH  producer payload.
- out_ready  in  REQ_WIDTH  per-consumer ready.
- out_valid  out  REQ_WIDTH  one-hot valid to the selected consumer; all zero when idle.
- out_data  out  DATA_WIDTH  held payload, shared by all consumers.
- bin  out  BIN_WIDTH  binary index of the current or last destination.

## Operation
- State: EMPTY / FULL. Registers: data_q, sel_q (BIN_WIDTH), ptr_q (BIN_WIDTH).
- Output handshake: out_valid[sel_q] & out_ready[sel_q] while FULL.
- in_ready = rst & (EMPTY | out handshake). This gives a combinational pass-through and sustains 1 word/cycle.
- Capture: in_valid & in_ready. The start pointer is:
  - sel_q + 1 (mod REQ_WIDTH) if an output handshake occurs in the same cycle;
  - otherwise ptr_q.
- Destination pick:
  - Use the first index i, scanning start, start+1, … with wrap, where out_ready[i]=1 in the capture cycle.
  - If no out_ready bit is set, pick start itself.
  - The pick is locked into sel_q and never re-evaluated while FULL.
- State transitions:
  - EMPTY→FULL on capture.
  - FULL→EMPTY on output handshake without capture.
  - FULL→FULL on handshake plus capture, or while the output waits.
- ptr_q updates to sel_q + 1 (mod REQ_WIDTH) on every output handshake; otherwise it holds. Wrap from REQ_WIDTH-1 goes to 0.
- Outputs while FULL:
  - out_valid = 1 << sel_q;
  - out_data = data_q;
  - bin = sel_q.
- Outputs while EMPTY:
  - out_valid = 0;
  - out_data and bin hold their last values.
- No word is dropped or duplicated; each captured word yields exactly one output handshake.

## Timing
- Reset values (after rising edge with rst=0):
  - state EMPTY; out_valid=0; out_data=0; bin=0; ptr_q=0; sel_q=0;
  - in_ready=0 while rst=0, and 1 in the first cycle after release.
- Latency: a word captured at edge N is presented (out_valid set) in cycle N→N+1.
- Throughput: 1 word/cycle when the selected consumer is ready every cycle.
- Backpressure: out_valid, out_data and bin must be stable while out_ready[sel_q]=0. In that state in_ready=0.
- Changes to out_ready bits other than sel_q while FULL do not affect the locked destination.
- Reset mid-operation drops any held word. out_valid=0 in the cycle after the reset edge. The pointer returns to 0.
- in_valid may drop at any time. in_data is sampled only on capture.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_data=8'h55. Required: out_valid=0, in_ready=0, bin=0 throughout. After release, in_ready=1 and the first word goes to bin 0.
- Full rotation: out_ready=8'hFF, stream 9 words 8'h10..8'h18 back-to-back.
  - bins must be 0,1,…,7,0 on consecutive cycles, with out_data matching.
  - in_ready stays 1 with no bubbles.
- Sparse ready: out_ready=8'hA5 constant, 6 words. Required: bins 0,2,5,7,0,2; out_valid 8'h01,8'h04,8'h20,8'h80,8'h01,8'h04.
- Backpressure: word 8'h33 locked to bin 3, with out_ready[3]=0 for 4 cycles while the other bits toggle.
  - out_valid=8'h08, out_data=8'h33 and in_ready=0 hold for those 4 cycles.
  - On out_ready[3]=1, the handshake happens and a simultaneous next word goes to bin 4 (out_ready=8'hFF).
- None ready: ptr=5, out_ready=0, capture 8'h77. Required: sel locks to 5.
  - Raising only out_ready[0] causes no handshake.
  - Raising out_ready[5] completes the handshake, and ptr becomes 6.
- Mid-operation reset: FULL with bin=6 and out_ready=0, then assert rst=0 for one edge. Required: out_valid=0, bin=0, ptr=0 afterwards. The held word is never delivered.
